debounce_scan: RTL

Multi-input debouncer that shares one wide prescaler counter among N button or switch inputs, instead of giving each input its own 24-bit counter. It sits between the board I/O pads and the CPU front-panel logic (reset, run/halt, single-step buttons). A scan FSM visits each input once per prescaler period. Each input needs only a small per-input agreement counter, and the block emits clean levels plus single-cycle edge pulses.

---
 rtl/debounce_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/debounce_scan.sv | 108 ++++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared types and constants for the scanned debouncer
package debounce_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    localparam int DEB_CW     = 24;
    localparam int DEB_STABLE = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer with parameterized width and reset value
module sync_2ff #(
    parameter int            W       = 1,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/debounce_scan.sv
// rtl/debounce_scan.sv - N-input debouncer sharing one prescaler, scanned one input per cycle
module debounce_scan
    import debounce_pkg::*;
#(
    parameter int   N      = 4,
    parameter int   CW     = DEB_CW,
    parameter int   STABLE = DEB_STABLE,
    parameter logic INIT   = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] width,
    input  logic [N-1:0]  dirty,
    output logic [N-1:0]  clean,
    output logic [N-1:0]  rise,
    output logic [N-1:0]  fall,
    output logic          scan_busy
);

    localparam int IW = (clog2(N) > 0) ? clog2(N) : 1;
    localparam int AW = clog2(STABLE + 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
    localparam logic [AW-1:0] AGR_LAST = AW'(STABLE - 1);

    state_t              state;
    state_t              state_nxt;
    logic [CW-1:0]       pcnt;
    logic [CW-1:0]       limit;
    logic [IW-1:0]       idx;
    logic [N-1:0][AW-1:0] agr;
    logic [N-1:0]        s;
    logic                pend_hit;
    logic                cur_s;
    logic                cur_c;

    sync_2ff #(
        .W       (N),
        .RST_VAL ({N{INIT}})
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (dirty),
        .q   (s)
    );

    // >= rather than == so a width lowered mid-count ends the idle phase at once
    assign limit    = (width == '0) ? '0 : width - CW'(1);
    assign pend_hit = (pcnt >= limit);
    assign cur_s    = s[idx];
    assign cur_c    = clean[idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (pend_hit) state_nxt = ST_SCAN;
            ST_SCAN: if (idx == IDX_LAST) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        scan_busy = (state == ST_SCAN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt  <= '0;
            idx   <= '0;
            agr   <= '0;
            clean <= {N{INIT}};
            rise  <= '0;
            fall  <= '0;
        end else begin
            rise <= '0;
            fall <= '0;
            if (state == ST_IDLE) begin
                if (pend_hit) begin
                    pcnt <= '0;
                    idx  <= '0;
                end else begin
                    pcnt <= pcnt + CW'(1);
                end
            end else begin
                pcnt <= '0;
                idx  <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
                // one disagreeing sample short of STABLE means this one flips the output
                if (cur_s != cur_c) begin
                    if (agr[idx] == AGR_LAST) begin
                        agr[idx]   <= '0;
                        clean[idx] <= cur_s;
                        rise[idx]  <= cur_s;
                        fall[idx]  <= ~cur_s;
                    end else begin
                        agr[idx] <= agr[idx] + AW'(1);
                    end
                end else begin
                    agr[idx] <= '0;
                end
            end
        end
    end

endmodule
